// File: rtl/trace_capture_ctrl.sv
// Trigger-aligned sensor trace capture controller.
// Delays after a trigger edge, then decimates samples into trace memory.
module trace_capture_ctrl #(
   parameter int DEPTH = 1024,
   parameter int AW    = 16
) (
   input  logic          w_clk,
   input  logic          rstn,
   input  logic          arm,
   input  logic          abort,
   input  logic          trigger,
   input  logic [15:0]   delay_cfg,
   input  logic [15:0]   length_cfg,
   input  logic [7:0]    decim_cfg,
   input  logic [7:0]    sensor_data,
   output logic          w_en,
   output logic [2:0]    w_memsel,
   output logic [AW-1:0] w_addr,
   output logic [7:0]    w_data,
   output logic          busy,
   output logic          done,
   output logic [15:0]   sample_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [15:0]   DEPTH_L  = 16'(DEPTH);
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);

   state_t        state_q, state_d;
   logic          trig_q, trig_d;
   logic [15:0]   dly_q, dly_d;
   logic [15:0]   len_q, len_d;
   logic [7:0]    dec_q, dec_d;
   logic [15:0]   timer_q, timer_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          w_en_q, w_en_d;
   logic [2:0]    w_memsel_q, w_memsel_d;
   logic [AW-1:0] w_addr_q, w_addr_d;
   logic [7:0]    w_data_q, w_data_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          trig_edge;
   logic [15:0]   len_clamp;

   assign trig_edge = trigger & ~trig_q;
   assign len_clamp = (length_cfg == 16'd0 || int'(length_cfg) > DEPTH)
                      ? DEPTH_L : length_cfg;

   // Next-state and next-output computation for the capture sequencer
   always_comb begin
      state_d    = state_q;
      trig_d     = trigger;
      dly_d      = dly_q;
      len_d      = len_q;
      dec_d      = dec_q;
      timer_d    = timer_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      w_en_d     = 1'b0;
      w_memsel_d = 3'b000;
      w_addr_d   = w_addr_q;
      w_data_d   = w_data_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state_d = S_ARMED;
                  dly_d   = delay_cfg;
                  len_d   = len_clamp;
                  dec_d   = decim_cfg;
                  cnt_d   = 16'd0;
                  addr_d  = '0;
                  timer_d = 16'd0;
               end
            end
            S_ARMED: begin
               if (trig_edge) begin
                  timer_d = (dly_q == 16'd0) ? 16'd0 : dly_q;
                  state_d = (dly_q == 16'd0) ? S_CAPTURE : S_DELAY;
               end
            end
            S_DELAY: begin
               if (timer_q <= 16'd1) begin
                  state_d = S_CAPTURE;
                  timer_d = 16'd0;
               end else begin
                  timer_d = timer_q - 16'd1;
               end
            end
            S_CAPTURE: begin
               if (timer_q == 16'd0) begin
                  w_en_d     = 1'b1;
                  w_memsel_d = 3'b001;
                  w_addr_d   = addr_q;
                  w_data_d   = sensor_data;
                  cnt_d      = cnt_q + 16'd1;
                  timer_d    = {8'h00, dec_q};
                  if (cnt_q + 16'd1 >= len_q) begin
                     state_d = S_DONE;
                  end else begin
                     addr_d = addr_q + ADDR_ONE;
                  end
               end else begin
                  timer_d = timer_q - 16'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d == S_ARMED) || (state_d == S_DELAY) ||
               (state_d == S_CAPTURE);
      done_d = (state_d == S_DONE);
   end

   // State and registered outputs; trigger history resets high
   always_ff @(posedge w_clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         trig_q     <= 1'b1;
         dly_q      <= 16'd0;
         len_q      <= 16'd0;
         dec_q      <= 8'd0;
         timer_q    <= 16'd0;
         addr_q     <= '0;
         cnt_q      <= 16'd0;
         w_en_q     <= 1'b0;
         w_memsel_q <= 3'b000;
         w_addr_q   <= '0;
         w_data_q   <= 8'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_q     <= trig_d;
         dly_q      <= dly_d;
         len_q      <= len_d;
         dec_q      <= dec_d;
         timer_q    <= timer_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         w_en_q     <= w_en_d;
         w_memsel_q <= w_memsel_d;
         w_addr_q   <= w_addr_d;
         w_data_q   <= w_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign w_en         = w_en_q;
   assign w_memsel     = w_memsel_q;
   assign w_addr       = w_addr_q;
   assign w_data       = w_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sample_count = cnt_q;

endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, trace memory depth in bytes (maximum capture length).
REQ-002 SHALL have parameter AW, default 16, trace memory address width.
REQ-003 w_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 arm  input  1  single-cycle pulse that starts a capture session.
REQ-006 abort  input  1  level/pulse that cancels any session.
REQ-007 trigger  input  1  cipher-start strobe; a rising edge starts the delay/capture sequence.
REQ-008 delay_cfg  input  16  cycles between the trigger edge and the first sample.
REQ-009 length_cfg  input  16  number of samples to store.
REQ-010 decim_cfg  input  8  store one sample every decim_cfg+1 cycles.
REQ-011 sensor_data  input  8  on-chip sensor sample, valid every cycle.
REQ-012 w_en  output  1  trace memory write strobe.
REQ-013 w_memsel  output  3  trace memory select.
REQ-014 w_addr  output  AW  trace memory write address.
REQ-015 w_data  output  8  trace memory write data.
REQ-016 busy  output  1  high in ARMED, DELAY and CAPTURE.
REQ-017 done  output  1  high in DONE.
REQ-018 sample_count  output  16  samples written in the current or last session.

Function
REQ-019 SHALL implement the states IDLE, ARMED, DELAY, CAPTURE and DONE; all outputs SHALL be registered.
REQ-020 IDLE or DONE with arm=1 -> ARMED:
- latch delay_cfg, length_cfg and decim_cfg into internal registers
- clear sample_count
- reset the address counter to 0
REQ-021 Latched length SHALL be clamped: 0 or greater than DEPTH becomes DEPTH.
REQ-022 arm SHALL be ignored in ARMED, DELAY and CAPTURE.
REQ-023 Rising edge SHALL be defined as trigger=1 at the current edge and trigger_q=0, where trigger_q is the previous sample of trigger.
- trigger_q is updated every cycle in all states.
- trigger_q resets to 1, so a trigger held high from reset produces no edge.
REQ-024 ARMED with a rising edge at clock edge T:
- latched delay 0 -> CAPTURE
- otherwise -> DELAY
- in both cases the first stored sample SHALL be sensor_data sampled at edge T+1+delay.
REQ-025 DELAY SHALL count down the latched delay and enter CAPTURE on the final count; trigger edges during DELAY or CAPTURE SHALL be ignored.
REQ-026 On every (decim+1)th edge in CAPTURE, starting at the first eligible edge, the block SHALL, at that same edge:
- set w_en=1
- set w_data=sensor_data sampled at that edge
- set w_addr=current address
- set w_memsel=3'b001
- then increment the address and sample_count.
REQ-027 On all non-write cycles, w_en=0 and w_memsel=3'b000; w_addr and w_data SHALL hold their last values.
REQ-028 w_en SHALL never be high for more than one cycle when decim>0, and SHALL be high for exactly length consecutive cycles when decim=0.
REQ-029 After the length-th write, the state SHALL go to DONE at that same edge, so w_en drops on the next edge; the address SHALL never exceed DEPTH-1 and SHALL never wrap.
REQ-030 DONE SHALL hold done=1 and sample_count=length until arm or abort.
REQ-031 abort=1 in any state -> IDLE at the next edge:
- w_en=0, busy=0, done=0
- sample_count keeps the number of samples actually written.
REQ-032 abort and arm in the same cycle: abort SHALL win.
REQ-033 Configuration inputs changing after arm SHALL have no effect on the current session.

Reset
REQ-034 rstn=0 SHALL immediately force, regardless of clock:
- state=IDLE, w_en=0, w_memsel=3'b000
- w_addr=0, w_data=0, busy=0, done=0, sample_count=0
- all internal counters=0, trigger_q=1.
REQ-035 Reset asserted mid-capture SHALL stop writes at once; after release, the block SHALL stay in IDLE until a new arm.

Verification
REQ-036 arm, delay=0, length=4, decim=0, sensor ramp 0x10,0x11..., trigger edge at T -> w_en high at T+1..T+4, addr 0..3, data 0x11..0x14 (the ramp value sampled at each of those edges); done at T+4; sample_count=4.
REQ-037 delay=5, length=3, decim=2 -> writes at T+6, T+9, T+12 to addr 0,1,2; w_en low in between.
REQ-038 length=0 -> exactly 1024 writes, last addr 1023, no wrap; done=1.
REQ-039 trigger held high through arm -> no capture; drop trigger and raise it again -> capture starts.
REQ-040 abort after 2 of 8 writes -> IDLE next edge, sample_count=2, busy=0; arm+abort together -> stays IDLE.
REQ-041 rstn pulsed low mid-CAPTURE -> outputs zero asynchronously; trigger edge after release -> no writes until arm.
